signext_pipe: RTL and testbench
===============================

Name: signext_pipe

Overview:
- Next-generation immediate generator for the LEGv8 datapath. Sits as a registered stage between instruction fetch/decode and execute.
- Decodes all LEGv8 immediate formats: D, CB, B, I, IW.
- Produces an N-bit immediate and a format code, with a PC/tag carried alongside.
- Valid/ready handshake through a 2-entry skid buffer, so the stage stalls without losing instructions; synchronous flush for branch redirects.

Parameters:
N, 64, immediate output width; legal values 32 or 64.
TAG_W, 64, width of the sideband tag (PC) carried with each instruction.
IMM_ZEXT, 0, I-type imm12 extension: 0 = sign-extend (legacy datapath compatibility), 1 = zero-extend.
BR_SHIFT, 0, 1 = CB/B-type offsets shifted left by 2 before output; 0 = raw word offset.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
flush  input  1  synchronous; discards all buffered entries.
in_valid  input  1  instruction word and tag valid.
in_ready  output  1  stage can accept; registered, equals "buffer not full".
instr  input  32  instruction word.
in_tag  input  TAG_W  PC/tag for instr.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head entry.
imm  output  N  extended immediate of head entry.
fmt  output  3  format of head entry: 0 NONE, 1 D, 2 CB, 3 B, 4 I, 5 IW.
out_tag  output  TAG_W  tag of head entry.
illegal  output  1  head entry is IW with hw not representable in N.

Behaviour:
- Decode is combinational on instr; results are written into the buffer on an accepted transfer (in_valid && in_ready).
- Decode table (first match wins):
  - a[31:21] = 7C2 (LDUR) or 7C0 (STUR): D, sext(a[20:12]).
  - a[31:24] = B4 (CBZ), B5 (CBNZ) or 54 (B.cond): CB, sext(a[23:5]).
  - a[31:26] = 05 (B) or 25 (BL): B, sext(a[25:0]).
  - a[31:22] = 244 (ADDI), 2C4 (ADDIS), 344 (SUBI) or 3C4 (SUBIS): I, a[21:10], extended per IMM_ZEXT.
  - a[31:23] = 1A5 (MOVZ) or 1E5 (MOVK): IW, zext(a[20:5]) << (16*a[22:21]).
  - Anything else: NONE, imm = 0.
- BR_SHIFT=1: CB and B results are shifted left 2 after extension. Bits above N are truncated; the sign is preserved by extending to N first.
- N=32, IW with a[22]=1: imm = 0, illegal = 1. illegal = 0 in every other case.
- Buffer: 2 entries, FIFO order, count in {0,1,2}.
  - in_ready = (count != 2), computed from the registered count.
  - out_valid = (count != 0).
  - Head fields (imm, fmt, out_tag, illegal) are driven from registers, not from instr.
- Latency: an instruction accepted in cycle k is presented at the head in cycle k+1 if the buffer was empty.
- Simultaneous push and pop:
  - count = 1: count stays 1; the new entry becomes head at the next edge.
  - count = 2: push is blocked because in_ready = 0; pop only.
- Head fields stay stable while out_valid && !out_ready.
- flush: count goes to 0 at the next edge and any same-cycle push is dropped. Flush has priority over push and pop.
- Reset (reset low, any time, asynchronous):
  - count = 0, out_valid = 0, in_ready = 1 once reset deasserts.
  - imm = 0, fmt = 0, out_tag = 0, illegal = 0.
  - Reset mid-transfer discards all entries.
- in_ready does not depend combinationally on out_ready, so there is no comb path from out_ready to in_ready.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0, imm=0, fmt=0; after release, in_ready=1 and the first accepted word appears one cycle later.
- LDUR with a[20:12]=1FF -> imm=FFFF_FFFF_FFFF_FFFF, fmt=1. CBZ with a[23:5]=7FFFF and BR_SHIFT=1 -> imm=FFFF_FFFF_FFFF_FFFC, fmt=2.
- ADDI with a[21:10]=800: IMM_ZEXT=0 -> imm=FFFF_FFFF_FFFF_F800; IMM_ZEXT=1 -> imm=0000_0000_0000_0800.
- MOVZ with imm16=1234, hw=3 -> imm=1234_0000_0000_0000, fmt=5. Same word with N=32 -> imm=0, illegal=1.
- out_ready=0 while pushing 3 words (tags 100, 104, 108) -> in_ready drops after 2 pushes and tag 108 is not accepted. Release out_ready -> tags 100 then 104 exit in order with no loss or duplication.
- count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1; the pushed word is discarded.

Source files
------------

// File: rtl/signext_pipe.sv
// LEGv8 immediate generator stage.
// Decodes the D, CB, B, I and IW immediate formats from a 32-bit instruction word.
// Each decoded immediate is held in a 2-entry skid buffer together with its
// format code, illegal flag and PC/tag. All head outputs come straight from
// registers. in_ready depends only on the registered occupancy.
module signext_pipe #(
  parameter int N        = 64,  // immediate width, 32 or 64
  parameter int TAG_W    = 64,  // sideband tag (PC) width
  parameter int IMM_ZEXT = 0,   // I-type imm12: 0 sign-extend, 1 zero-extend
  parameter int BR_SHIFT = 0    // 1: CB/B offsets become byte offsets (<<2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     imm,
  output logic [2:0]       fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_D    = 3'd1;
  localparam logic [2:0] FMT_CB   = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;

  // Extension helpers. Everything is widened to 64 bits before any shift or
  // truncation, so the sign survives into an N-bit result.
  function automatic logic [63:0] sext9(input logic [8:0] v);
    return {{55{v[8]}}, v};
  endfunction

  function automatic logic [63:0] sext19(input logic [18:0] v);
    return {{45{v[18]}}, v};
  endfunction

  function automatic logic [63:0] sext26(input logic [25:0] v);
    return {{38{v[25]}}, v};
  endfunction

  function automatic logic [63:0] ext12(input logic [11:0] v);
    if (IMM_ZEXT != 0) return {52'd0, v};
    return {{52{v[11]}}, v};
  endfunction

  // Word offsets become byte offsets when the datapath wants them. The top two
  // bits are dropped, which is the truncation of the 64-bit value.
  function automatic logic [63:0] br_scale(input logic [63:0] v);
    if (BR_SHIFT != 0) return {v[61:0], 2'b00};
    return v;
  endfunction

  // ---- stage p0: combinational decode of the incoming word ----
  logic [63:0] dec_imm64_p0;
  logic [N-1:0] dec_imm_p0;
  logic [2:0]   dec_fmt_p0;
  logic         dec_ill_p0;
  logic [1:0]   hw_p0;

  assign hw_p0 = instr[22:21];

  // Decode table: the first matching opcode wins.
  always_comb begin
    dec_imm64_p0 = 64'd0;
    dec_fmt_p0   = FMT_NONE;
    dec_ill_p0   = 1'b0;
    if (instr[31:21] == 11'h7C2 || instr[31:21] == 11'h7C0) begin
      dec_fmt_p0   = FMT_D;
      dec_imm64_p0 = sext9(instr[20:12]);
    end else if (instr[31:24] == 8'hB4 || instr[31:24] == 8'hB5 ||
                 instr[31:24] == 8'h54) begin
      dec_fmt_p0   = FMT_CB;
      dec_imm64_p0 = br_scale(sext19(instr[23:5]));
    end else if (instr[31:26] == 6'h05 || instr[31:26] == 6'h25) begin
      dec_fmt_p0   = FMT_B;
      dec_imm64_p0 = br_scale(sext26(instr[25:0]));
    end else if (instr[31:22] == 10'h244 || instr[31:22] == 10'h2C4 ||
                 instr[31:22] == 10'h344 || instr[31:22] == 10'h3C4) begin
      dec_fmt_p0   = FMT_I;
      dec_imm64_p0 = ext12(instr[21:10]);
    end else if (instr[31:23] == 9'h1A5 || instr[31:23] == 9'h1E5) begin
      dec_fmt_p0 = FMT_IW;
      // A 32-bit datapath cannot place the halfword at bit 32 or 48.
      if (N == 32 && hw_p0[1]) begin
        dec_ill_p0   = 1'b1;
        dec_imm64_p0 = 64'd0;
      end else begin
        dec_imm64_p0 = {48'd0, instr[20:5]} << {hw_p0, 4'b0000};
      end
    end
  end

  assign dec_imm_p0 = dec_imm64_p0[N-1:0];

  // ---- stage p1: two-entry buffer, head slot feeds the outputs ----
  logic [1:0]       count_p1;
  logic [N-1:0]     hd_imm_p1;
  logic [2:0]       hd_fmt_p1;
  logic [TAG_W-1:0] hd_tag_p1;
  logic             hd_ill_p1;
  logic [N-1:0]     sk_imm_p1;
  logic [2:0]       sk_fmt_p1;
  logic [TAG_W-1:0] sk_tag_p1;
  logic             sk_ill_p1;
  logic             push;
  logic             pop;

  assign in_ready  = (count_p1 != 2'd2);
  assign out_valid = (count_p1 != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign imm     = hd_imm_p1;
  assign fmt     = hd_fmt_p1;
  assign out_tag = hd_tag_p1;
  assign illegal = hd_ill_p1;

  // Occupancy. Flush overrides both push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_p1 <= 2'd0;
    end else if (flush) begin
      count_p1 <= 2'd0;
    end else if (push && !pop) begin
      count_p1 <= count_p1 + 2'd1;
    end else if (pop && !push) begin
      count_p1 <= count_p1 - 2'd1;
    end
  end

  // Head slot: load a new entry into an empty buffer or on a push-with-pop.
  // When the buffer is full and drains, the skid entry moves up. Otherwise
  // the head holds its value, so it stays stable while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hd_imm_p1 <= '0;
      hd_fmt_p1 <= FMT_NONE;
      hd_tag_p1 <= '0;
      hd_ill_p1 <= 1'b0;
    end else if (!flush) begin
      if ((count_p1 == 2'd0 && push) || (count_p1 == 2'd1 && push && pop)) begin
        hd_imm_p1 <= dec_imm_p0;
        hd_fmt_p1 <= dec_fmt_p0;
        hd_tag_p1 <= in_tag;
        hd_ill_p1 <= dec_ill_p0;
      end else if (count_p1 == 2'd2 && pop) begin
        hd_imm_p1 <= sk_imm_p1;
        hd_fmt_p1 <= sk_fmt_p1;
        hd_tag_p1 <= sk_tag_p1;
        hd_ill_p1 <= sk_ill_p1;
      end
    end
  end

  // Skid slot: catches the second entry when the head is occupied and stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sk_imm_p1 <= '0;
      sk_fmt_p1 <= FMT_NONE;
      sk_tag_p1 <= '0;
      sk_ill_p1 <= 1'b0;
    end else if (!flush && count_p1 == 2'd1 && push && !pop) begin
      sk_imm_p1 <= dec_imm_p0;
      sk_fmt_p1 <= dec_fmt_p0;
      sk_tag_p1 <= in_tag;
      sk_ill_p1 <= dec_ill_p0;
    end
  end

endmodule

// File: tb/tb_signext_pipe.sv
// Testbench for signext_pipe. Two configurations share one stimulus stream:
//   a: N=64, IMM_ZEXT=0, BR_SHIFT=1
//   b: N=32, IMM_ZEXT=1, BR_SHIFT=0
module tb_signext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] in_tag;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [63:0] a_imm, a_out_tag;
  logic [2:0]  a_fmt;
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_imm;
  logic [63:0] b_out_tag;
  logic [2:0]  b_fmt;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] w; logic [63:0] tag; } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  signext_pipe #(.N(64), .TAG_W(64), .IMM_ZEXT(0), .BR_SHIFT(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .instr(instr), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .imm(a_imm),
    .fmt(a_fmt), .out_tag(a_out_tag), .illegal(a_illegal));

  signext_pipe #(.N(32), .TAG_W(64), .IMM_ZEXT(1), .BR_SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .instr(instr), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .imm(b_imm),
    .fmt(b_fmt), .out_tag(b_out_tag), .illegal(b_illegal));

  // Reference decode from the format rules using integer arithmetic.
  function automatic void model(input logic [31:0] a, input int n, input int zx,
                                input int bs, output logic [63:0] e_imm,
                                output logic [2:0] e_fmt, output logic e_ill);
    longint v = 0;
    longint p = 1;
    int hw;
    logic [63:0] mask;
    logic [63:0] t;
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e_fmt = 3'd0;
    e_ill = 1'b0;
    if (a[31:21] == 11'h7C2 || a[31:21] == 11'h7C0) begin
      e_fmt = 3'd1;
      v = longint'(a[20:12]);
      if (v >= 256) v = v - 512;
    end else if (a[31:24] == 8'hB4 || a[31:24] == 8'hB5 || a[31:24] == 8'h54) begin
      e_fmt = 3'd2;
      v = longint'(a[23:5]);
      if (v >= 262144) v = v - 524288;
      if (bs != 0) v = v * 4;
    end else if (a[31:26] == 6'h05 || a[31:26] == 6'h25) begin
      e_fmt = 3'd3;
      v = longint'(a[25:0]);
      if (v >= 33554432) v = v - 67108864;
      if (bs != 0) v = v * 4;
    end else if (a[31:22] == 10'h244 || a[31:22] == 10'h2C4 ||
                 a[31:22] == 10'h344 || a[31:22] == 10'h3C4) begin
      e_fmt = 3'd4;
      v = longint'(a[21:10]);
      if (zx == 0 && v >= 2048) v = v - 4096;
    end else if (a[31:23] == 9'h1A5 || a[31:23] == 9'h1E5) begin
      e_fmt = 3'd5;
      hw = int'(a[22:21]);
      if (n == 32 && hw >= 2) begin
        e_ill = 1'b1;
        v = 0;
      end else begin
        repeat (hw) p = p * 65536;
        v = longint'(a[20:5]) * p;
      end
    end
    t = v;
    e_imm = t & mask;
  endfunction

  // Random instruction biased toward each immediate format.
  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: w[31:21] = ($urandom_range(0, 1) == 1) ? 11'h7C2 : 11'h7C0;
      1: case ($urandom_range(0, 2))
           0: w[31:24] = 8'hB4;
           1: w[31:24] = 8'hB5;
           default: w[31:24] = 8'h54;
         endcase
      2: w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h05 : 6'h25;
      3: case ($urandom_range(0, 3))
           0: w[31:22] = 10'h244;
           1: w[31:22] = 10'h2C4;
           2: w[31:22] = 10'h344;
           default: w[31:22] = 10'h3C4;
         endcase
      4: w[31:23] = ($urandom_range(0, 1) == 1) ? 9'h1A5 : 9'h1E5;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    instr = {11'h7C2, 9'h1FF, 12'h000}; in_tag = 64'hAA;
    repeat (3) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%b exp=0", a_out_valid); end
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rst_b_valid got=%b exp=0", b_out_valid); end
    checks++; if (a_imm !== 64'd0) begin failures++; $display("FAIL rst_a_imm got=%h exp=0", a_imm); end
    checks++; if (a_fmt !== 3'd0) begin failures++; $display("FAIL rst_a_fmt got=%0d exp=0", a_fmt); end
    checks++; if (a_out_tag !== 64'd0) begin failures++; $display("FAIL rst_a_tag got=%h exp=0", a_out_tag); end
    checks++; if (b_illegal !== 1'b0) begin failures++; $display("FAIL rst_b_ill got=%b exp=0", b_illegal); end
    reset = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_a_rdy got=%b exp=1", a_in_ready); end
    checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL rst_b_rdy got=%b exp=1", b_in_ready); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL first_a_valid got=%b exp=1", a_out_valid); end
    checks++; if (a_out_tag !== 64'hAA) begin failures++; $display("FAIL first_a_tag got=%h exp=aa", a_out_tag); end
    checks++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL first_a_imm got=%h exp=ffffffffffffffff", a_imm); end
    checks++; if (a_fmt !== 3'd1) begin failures++; $display("FAIL first_a_fmt got=%0d exp=1", a_fmt); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL first_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_formats();
    logic [31:0] w [8];
    logic [63:0] ea [8];
    logic [31:0] eb [8];
    logic [2:0]  ef [8];
    logic        ebi [8];
    w[0] = {11'h7C2, 9'h1FF, 12'h000};          ea[0] = 64'hFFFF_FFFF_FFFF_FFFF; eb[0] = 32'hFFFF_FFFF; ef[0] = 3'd1; ebi[0] = 1'b0;
    w[1] = {8'hB4, 19'h7FFFF, 5'h00};           ea[1] = 64'hFFFF_FFFF_FFFF_FFFC; eb[1] = 32'hFFFF_FFFF; ef[1] = 3'd2; ebi[1] = 1'b0;
    w[2] = {10'h244, 12'h800, 10'h000};         ea[2] = 64'hFFFF_FFFF_FFFF_F800; eb[2] = 32'h0000_0800; ef[2] = 3'd4; ebi[2] = 1'b0;
    w[3] = {9'h1A5, 2'd3, 16'h1234, 5'h00};     ea[3] = 64'h1234_0000_0000_0000; eb[3] = 32'h0;         ef[3] = 3'd5; ebi[3] = 1'b1;
    w[4] = {6'h05, 26'h0000001};                ea[4] = 64'h4;                   eb[4] = 32'h1;         ef[4] = 3'd3; ebi[4] = 1'b0;
    w[5] = 32'h0000_0000;                       ea[5] = 64'h0;                   eb[5] = 32'h0;         ef[5] = 3'd0; ebi[5] = 1'b0;
    w[6] = {9'h1E5, 2'd1, 16'hABCD, 5'h00};     ea[6] = 64'hABCD_0000;           eb[6] = 32'hABCD_0000; ef[6] = 3'd5; ebi[6] = 1'b0;
    w[7] = {8'h54, 19'h00010, 5'h03};           ea[7] = 64'h40;                  eb[7] = 32'h10;        ef[7] = 3'd2; ebi[7] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; instr = w[i]; in_tag = 64'h1000 + 64'(i);
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_out_tag !== 64'h1000 + 64'(i)) begin failures++; $display("FAIL fmt%0d_a_head got=%b/%h exp=1/%h", i, a_out_valid, a_out_tag, 64'h1000 + 64'(i)); end
      checks++; if (a_imm !== ea[i]) begin failures++; $display("FAIL fmt%0d_a_imm got=%h exp=%h", i, a_imm, ea[i]); end
      checks++; if (a_fmt !== ef[i] || a_illegal !== 1'b0) begin failures++; $display("FAIL fmt%0d_a_code got=%0d/%b exp=%0d/0", i, a_fmt, a_illegal, ef[i]); end
      checks++; if (b_imm !== eb[i]) begin failures++; $display("FAIL fmt%0d_b_imm got=%h exp=%h", i, b_imm, eb[i]); end
      checks++; if (b_fmt !== ef[i] || b_illegal !== ebi[i]) begin failures++; $display("FAIL fmt%0d_b_code got=%0d/%b exp=%0d/%b", i, b_fmt, b_illegal, ef[i], ebi[i]); end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    instr = {11'h7C0, 9'h005, 12'h000};
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 64'h100;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || a_out_tag !== 64'h100) begin failures++; $display("FAIL bp_one got=%b/%h exp=1/100", a_in_ready, a_out_tag); end
    in_tag = 64'h104;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b/%b exp=0/0", a_in_ready, b_in_ready); end
    in_tag = 64'h108;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0 || a_out_tag !== 64'h100 || a_imm !== 64'h5) begin failures++; $display("FAIL bp_stall got=%b/%h/%h exp=0/100/5", a_in_ready, a_out_tag, a_imm); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_tag !== 64'h104 || b_out_tag !== 64'h104) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/104", a_out_valid, a_out_tag); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_nolose got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0; in_tag = 64'h200;
    @(negedge clk);
    in_tag = 64'h204;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL fl_full got=%b exp=0", a_in_ready); end
    flush = 1'b1; in_tag = 64'h208;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin failures++; $display("FAIL fl_empty got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fl_dropped got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = {6'h25, 26'h3FFFFFF}; in_tag = 64'h300;
    @(negedge clk);
    in_tag = 64'h304;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL arst_ctrl got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
    checks++; if (a_imm !== 64'd0 || a_out_tag !== 64'd0 || a_fmt !== 3'd0) begin failures++; $display("FAIL arst_data got=%h/%h/%0d exp=0/0/0", a_imm, a_out_tag, a_fmt); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin failures++; $display("FAIL arst_discard got=%b/%b exp=0/0", a_out_valid, b_out_valid); end
  endtask

  task automatic test_random();
    logic [63:0] ea, eb;
    logic [2:0]  fa, fb;
    logic        ia, ib;
    logic        do_push, do_pop;
    ent_t        e;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== (q.size() != 0) || b_out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b/%b exp=%b", c, a_out_valid, b_out_valid, (q.size() != 0)); end
      checks++; if (a_in_ready !== (q.size() != 2) || b_in_ready !== (q.size() != 2)) begin failures++; $display("FAIL rnd_ready c=%0d got=%b/%b exp=%b", c, a_in_ready, b_in_ready, (q.size() != 2)); end
      if (q.size() != 0) begin
        model(q[0].w, 64, 0, 1, ea, fa, ia);
        model(q[0].w, 32, 1, 0, eb, fb, ib);
        checks++; if (a_imm !== ea || a_fmt !== fa || a_illegal !== ia) begin failures++; $display("FAIL rnd_a c=%0d w=%h got=%h/%0d/%b exp=%h/%0d/%b", c, q[0].w, a_imm, a_fmt, a_illegal, ea, fa, ia); end
        checks++; if ({32'h0, b_imm} !== eb || b_fmt !== fb || b_illegal !== ib) begin failures++; $display("FAIL rnd_b c=%0d w=%h got=%h/%0d/%b exp=%h/%0d/%b", c, q[0].w, b_imm, b_fmt, b_illegal, eb, fb, ib); end
        checks++; if (a_out_tag !== q[0].tag || b_out_tag !== q[0].tag) begin failures++; $display("FAIL rnd_tag c=%0d got=%h/%h exp=%h", c, a_out_tag, b_out_tag, q[0].tag); end
      end
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      instr     = gen_word();
      in_tag    = {$urandom, $urandom};
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = out_ready && (q.size() != 0);
        do_push = in_valid && (q.size() != 2);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.w = instr; e.tag = in_tag;
          q.push_back(e);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
